ctrl_fsm: RTL
=============

Name: ctrl_fsm

Overview:
Multi-cycle control unit directly upstream of the 9-bit-instruction datapath. It consumes opcode[3:0], fcode and DONE, and drives every CTRL_* select, the datapath START/init pulse, and a PC-hold stall so that loads take a fixed multi-cycle slot. It also sequences program start, halt and retirement counting for the test harness.

Parameters:
INIT_CYCLES, 2, number of cycles START is held high after a run request (must be >= 1)
LOAD_WAIT, 1, extra cycles a load (LW) spends in MEM_WAIT before write-back (must be >= 1)
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
run_req  in  1  one-cycle request to start a program; sampled only in IDLE or HALT
opcode  in  4  instr[8:5] from the datapath
fcode  in  1  instr[0] from the datapath
done_in  in  1  DONE from the datapath fetch stage
START  out  1  datapath init/reset
pc_hold  out  1  freezes PC fetch for this cycle
CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem  out  1 each  datapath selects
CTRL_alu_op  out  3  ALU operation
busy  out  1  high in INIT, RUN and MEM_WAIT
halted  out  1  high in HALT
instr_count  out  CNT_W  instructions retired since last INIT

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, wait counter=0, instr_count=0. All outputs are 0 except START=1; START stays high in IDLE so the datapath is held in init.
- States: IDLE, INIT, RUN, MEM_WAIT, HALT.
- IDLE: on run_req go to INIT.
- INIT: START=1 for exactly INIT_CYCLES cycles, then go to RUN. instr_count is cleared on entry. All CTRL_*=0.
- RUN: CTRL_* are combinational decodes of opcode/fcode (Mealy). One instruction retires per cycle, and instr_count increments by 1 on each retire. The counter wraps modulo 2^CNT_W.
- Opcode map:
  - 0 LW: read_mem=1, pc_hold=1, no write; go to MEM_WAIT.
  - 1 SW: write_mem=1.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 14 SLT: reg_write_en=1, alu_op=0,1,2,3,6 respectively.
  - 6 SHL, 7 SHR: alu_op=4/5, alu_sc_in=fcode, reg_write_en=1.
  - 8 ADDI: alu_src=1, alu_op=0, reg_write_en=1.
  - 9 BRZ: branch_rel_z=1, alu_op=7.
  - 10 BRNZ: branch_rel_nz=1, alu_op=7.
  - 11 JMP: branch_abs=1.
  - 12 JMPR: branch_abs=1, lut_in=1.
  - 13 CALL: reg_sel=1, reg_write_en=1.
  - 15: fcode=0 is NOP (all 0); fcode=1 is HALT, which goes to HALT and does not retire.
- MEM_WAIT: read_mem=1 and pc_hold=1 for LOAD_WAIT-1 cycles. On the final cycle: read_mem=1, mem_to_reg=1, reg_write_en=1, pc_hold=0, the LW retires, and the FSM returns to RUN. The LW's decoded opcode is latched on entry, so opcode changes during MEM_WAIT are ignored.
- done_in high in RUN: go to HALT next cycle; the current instruction still retires. done_in is ignored in IDLE, INIT and MEM_WAIT; a load completes first, then done_in is re-checked in RUN.
- HALT: all CTRL_*=0, pc_hold=1, halted=1, instr_count frozen. run_req goes to INIT.
- run_req in INIT, RUN or MEM_WAIT is ignored.
- reset_n asserted mid-operation (e.g. in MEM_WAIT): immediate return to IDLE; no partial write-back occurs.
- Write and branch strobes are never asserted outside RUN or the final MEM_WAIT cycle. At most one branch_* strobe is high at a time.

Decomposition:
- Package ctrl_pkg: the state enum; the opcode enum (LW..SYS=15); the alu_op localparams (ADD=0, SUB=1, AND=2, OR=3, SHL=4, SHR=5, SLT=6, PASS=7); a ctrl_bundle_t struct holding all CTRL_* fields.
- Sub-module ctrl_decode: purely combinational opcode/fcode to ctrl_bundle_t. The FSM gates and overrides its output per state.

Test Plan:
- Reset then run_req: START high for 2 cycles, RUN on the 3rd cycle, busy=1, instr_count=0.
- ADD (opcode 2) in RUN: reg_write_en=1, alu_op=0, alu_src=0, and instr_count goes 0->1 next edge.
- LW with LOAD_WAIT=1: cycle 0 read_mem=1, pc_hold=1, reg_write_en=0; cycle 1 mem_to_reg=1, reg_write_en=1, pc_hold=0; instr_count +1 only after cycle 1.
- opcode 15 / fcode 1: halted=1 next cycle, all CTRL_*=0; run_req in HALT restarts INIT and clears the count.
- done_in pulse while in MEM_WAIT: the load completes, then HALT follows one cycle after RUN sees done_in still high.
- reset_n low mid-MEM_WAIT: all outputs 0 except START=1 the same cycle (asynchronously); instr_count=0; run_req while busy has no effect.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcode map,
// ALU operation codes and the bundle of datapath select lines.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT
  } state_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LW   = 4'd0,
    OP_SW   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ADDI = 4'd8,
    OP_BRZ  = 4'd9,
    OP_BRNZ = 4'd10,
    OP_JMP  = 4'd11,
    OP_JMPR = 4'd12,
    OP_CALL = 4'd13,
    OP_SLT  = 4'd14,
    OP_SYS  = 4'd15
  } opcode_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SHL  = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHR  = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'd7;

  typedef struct packed {
    logic                branch_rel_nz;
    logic                branch_rel_z;
    logic                branch_abs;
    logic                reg_write_en;
    logic                reg_sel;
    logic                lut_in;
    logic                mem_to_reg;
    logic                alu_src;
    logic                alu_sc_in;
    logic                read_mem;
    logic                write_mem;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure opcode/fcode decoder; the FSM decides when these selects reach the datapath.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                fcode,
  output ctrl_bundle_t        ctrl,
  output logic                is_load,
  output logic                is_halt
);

  always_comb begin
    ctrl    = '0;
    is_load = 1'b0;
    is_halt = 1'b0;
    case (opcode_t'(opcode))
      OP_LW: begin
        ctrl.read_mem = 1'b1;
        is_load       = 1'b1;
      end
      OP_SW:   ctrl.write_mem = 1'b1;
      OP_ADD:  begin ctrl.reg_write_en = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_SUB:  begin ctrl.reg_write_en = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_AND:  begin ctrl.reg_write_en = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_OR:   begin ctrl.reg_write_en = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_SLT:  begin ctrl.reg_write_en = 1'b1; ctrl.alu_op = ALU_SLT; end
      OP_SHL: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_op       = ALU_SHL;
        ctrl.alu_sc_in    = fcode;
      end
      OP_SHR: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_op       = ALU_SHR;
        ctrl.alu_sc_in    = fcode;
      end
      OP_ADDI: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.alu_op       = ALU_ADD;
      end
      OP_BRZ:  begin ctrl.branch_rel_z  = 1'b1; ctrl.alu_op = ALU_PASS; end
      OP_BRNZ: begin ctrl.branch_rel_nz = 1'b1; ctrl.alu_op = ALU_PASS; end
      OP_JMP:  ctrl.branch_abs = 1'b1;
      OP_JMPR: begin ctrl.branch_abs = 1'b1; ctrl.lut_in = 1'b1; end
      OP_CALL: begin ctrl.reg_sel = 1'b1; ctrl.reg_write_en = 1'b1; end
      OP_SYS:  is_halt = fcode;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: sequences init/run/load-wait/halt around the
// combinational decoder and counts retired instructions.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned LOAD_WAIT   = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                run_req,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                fcode,
  input  logic                done_in,
  output logic                START,
  output logic                pc_hold,
  output logic                CTRL_branch_rel_nz,
  output logic                CTRL_branch_rel_z,
  output logic                CTRL_branch_abs,
  output logic                CTRL_reg_write_en,
  output logic                CTRL_reg_sel,
  output logic                CTRL_lut_in,
  output logic                CTRL_mem_to_reg,
  output logic                CTRL_alu_src,
  output logic                CTRL_alu_sc_in,
  output logic                CTRL_read_mem,
  output logic                CTRL_write_mem,
  output logic [ALU_OP_W-1:0] CTRL_alu_op,
  output logic                busy,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int unsigned WAIT_MAX = (INIT_CYCLES > LOAD_WAIT) ? INIT_CYCLES : LOAD_WAIT;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_bundle_t       load_q, load_d;
  ctrl_bundle_t       dec_ctrl, ctrl;
  logic               dec_load, dec_halt;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .fcode   (fcode),
    .ctrl    (dec_ctrl),
    .is_load (dec_load),
    .is_halt (dec_halt)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    ctrl    = '0;
    START   = 1'b0;
    pc_hold = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        START = 1'b1;
        if (run_req) begin
          state_d = ST_INIT;
          wait_d  = WAIT_W'(INIT_CYCLES - 1);
          cnt_d   = '0;
        end
      end
      ST_INIT: begin
        START = 1'b1;
        busy  = 1'b1;
        if (wait_q == '0) state_d = ST_RUN;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      ST_RUN: begin
        busy = 1'b1;
        ctrl = dec_ctrl;
        // A load owns the slot: done_in is only honoured once it has written back.
        if (dec_load) begin
          pc_hold = 1'b1;
          load_d  = dec_ctrl;
          wait_d  = WAIT_W'(LOAD_WAIT - 1);
          state_d = ST_MEM_WAIT;
        end else if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (done_in) state_d = ST_HALT;
        end
      end
      ST_MEM_WAIT: begin
        busy          = 1'b1;
        ctrl          = load_q;
        ctrl.read_mem = 1'b1;
        if (wait_q == '0) begin
          ctrl.mem_to_reg   = 1'b1;
          ctrl.reg_write_en = 1'b1;
          cnt_d             = cnt_q + CNT_W'(1);
          state_d           = ST_RUN;
        end else begin
          pc_hold = 1'b1;
          wait_d  = wait_q - WAIT_W'(1);
        end
      end
      ST_HALT: begin
        pc_hold = 1'b1;
        halted  = 1'b1;
        if (run_req) begin
          state_d = ST_INIT;
          wait_d  = WAIT_W'(INIT_CYCLES - 1);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign CTRL_branch_rel_nz = ctrl.branch_rel_nz;
  assign CTRL_branch_rel_z  = ctrl.branch_rel_z;
  assign CTRL_branch_abs    = ctrl.branch_abs;
  assign CTRL_reg_write_en  = ctrl.reg_write_en;
  assign CTRL_reg_sel       = ctrl.reg_sel;
  assign CTRL_lut_in        = ctrl.lut_in;
  assign CTRL_mem_to_reg    = ctrl.mem_to_reg;
  assign CTRL_alu_src       = ctrl.alu_src;
  assign CTRL_alu_sc_in     = ctrl.alu_sc_in;
  assign CTRL_read_mem      = ctrl.read_mem;
  assign CTRL_write_mem     = ctrl.write_mem;
  assign CTRL_alu_op        = ctrl.alu_op;
  assign instr_count        = cnt_q;

endmodule
